// File: rtl/rete_pkg.sv
// rete_pkg: shared widths, FSM encoding and settle-count bounds for arbitro_rete_b.
// Rev 1.0
`default_nettype none

package rete_pkg;

  localparam int W_OP       = 16;
  localparam int W_RES      = 4;
  localparam int W_CNT      = 4;
  localparam int SETTLE_MIN = 1;
  localparam int SETTLE_MAX = 15;

  typedef enum logic [1:0] {
    IDLE     = 2'b00,
    SETTLE   = 2'b01,
    ACK_WAIT = 2'b10
  } state_t;

endpackage

`default_nettype wire

// File: rtl/arbitro_rete_b_sel_rr2.sv
// sel_rr2: two-way winner select, round-robin on last; fixed priority under ARBITRO_PRIO_FISSA_EN.
// Rev 1.0
`default_nettype none

module sel_rr2 (
  input  logic req0,
  input  logic req1,
`ifndef ARBITRO_PRIO_FISSA_EN
  input  logic last,
`endif
  output logic winner
);

`ifdef ARBITRO_PRIO_FISSA_EN
  assign winner = req1 & ~req0;
`else
  // Contention goes to the client that was not served last.
  assign winner = req1 & (~req0 | ~last);
`endif

endmodule

`default_nettype wire

// File: rtl/arbitro_rete_b.sv
// arbitro_rete_b: shares one combinational type-B net between two four-phase req/ack clients.
// Optional ARBITRO_PRIO_FISSA_EN: fixed priority to client 0 instead of round-robin. Rev 1.0
`default_nettype none

module arbitro_rete_b
  import rete_pkg::*;
#(
  parameter int SETTLE_CYCLES = 2
) (
  input  logic              clock,
  input  logic              reset_,
  input  logic              req0,
  input  logic [W_OP-1:0]   op0,
  output logic              ack0,
  input  logic              req1,
  input  logic [W_OP-1:0]   op1,
  output logic              ack1,
  output logic [W_RES-1:0]  dato,
  output logic [W_OP-1:0]   x15_x0_b,
  input  logic [W_RES-1:0]  z3_z0_b,
  output logic              grant,
  output logic              busy
);

  localparam int SETTLE_EFF =
    (SETTLE_CYCLES < SETTLE_MIN) ? SETTLE_MIN :
    (SETTLE_CYCLES > SETTLE_MAX) ? SETTLE_MAX : SETTLE_CYCLES;
  localparam logic [W_CNT-1:0] CNT_LOAD = W_CNT'(SETTLE_EFF - 1);

  state_t              state, state_n;
  logic [W_CNT-1:0]    cnt, cnt_n;
  logic                grant_n, busy_n, ack0_n, ack1_n;
  logic [W_RES-1:0]    dato_n;
  logic [W_OP-1:0]     x_n;
  logic                winner;
  logic                req_granted;

`ifndef ARBITRO_PRIO_FISSA_EN
  logic last, last_n;

  sel_rr2 u_sel (
    .req0   (req0),
    .req1   (req1),
    .last   (last),
    .winner (winner)
  );
`else
  sel_rr2 u_sel (
    .req0   (req0),
    .req1   (req1),
    .winner (winner)
  );
`endif

  assign req_granted = grant ? req1 : req0;

  always_comb begin
    state_n = state;
    cnt_n   = cnt;
    grant_n = grant;
    busy_n  = busy;
    ack0_n  = ack0;
    ack1_n  = ack1;
    dato_n  = dato;
    x_n     = x15_x0_b;
`ifndef ARBITRO_PRIO_FISSA_EN
    last_n  = last;
`endif
    case (state)
      IDLE: begin
        if (req0 | req1) begin
          grant_n = winner;
          x_n     = winner ? op1 : op0;
          cnt_n   = CNT_LOAD;
          busy_n  = 1'b1;
          state_n = SETTLE;
        end
      end
      SETTLE: begin
        // The operand stays frozen here even if the client drops req early.
        if (cnt == '0) begin
          dato_n = z3_z0_b;
          if (grant) ack1_n = 1'b1;
          else       ack0_n = 1'b1;
          state_n = ACK_WAIT;
        end else begin
          cnt_n = cnt - 1'b1;
        end
      end
      ACK_WAIT: begin
        if (!req_granted) begin
          ack0_n  = 1'b0;
          ack1_n  = 1'b0;
          busy_n  = 1'b0;
`ifndef ARBITRO_PRIO_FISSA_EN
          last_n  = grant;
`endif
          state_n = IDLE;
        end
      end
      default: begin
        ack0_n  = 1'b0;
        ack1_n  = 1'b0;
        busy_n  = 1'b0;
        state_n = IDLE;
      end
    endcase
  end

  always_ff @(posedge clock or negedge reset_) begin
    if (!reset_) begin
      state    <= IDLE;
      cnt      <= '0;
      grant    <= 1'b0;
      busy     <= 1'b0;
      ack0     <= 1'b0;
      ack1     <= 1'b0;
      dato     <= '0;
      x15_x0_b <= '0;
`ifndef ARBITRO_PRIO_FISSA_EN
      last     <= 1'b1;
`endif
    end else begin
      state    <= state_n;
      cnt      <= cnt_n;
      grant    <= grant_n;
      busy     <= busy_n;
      ack0     <= ack0_n;
      ack1     <= ack1_n;
      dato     <= dato_n;
      x15_x0_b <= x_n;
`ifndef ARBITRO_PRIO_FISSA_EN
      last     <= last_n;
`endif
    end
  end

endmodule

`default_nettype wire

// File: tb/tb_arbitro_rete_b.sv
// tb_arbitro_rete_b: directed vectors for arbitro_rete_b at SETTLE_CYCLES = 2, 1 and 15.
`default_nettype none

module tb_arbitro_rete_b;

  logic        clock = 1'b0;
  logic        reset_ = 1'b0;
  logic        req0 = 1'b0, req1 = 1'b0;
  logic [15:0] op0 = '0, op1 = '0;

  logic        ack0, ack1, grant, busy;
  logic [3:0]  dato, z;
  logic [15:0] xb;
  logic        ack0_s1, ack1_s1, grant_s1, busy_s1;
  logic [3:0]  dato_s1, z_s1;
  logic [15:0] xb_s1;
  logic        ack0_s15, ack1_s15, grant_s15, busy_s15;
  logic [3:0]  dato_s15, z_s15;
  logic [15:0] xb_s15;

  int vectors = 0;
  int miscompares = 0;

  // Stand-in for the type-B net: A5A5->7, 0001->9, 1234->F, 00F0->7.
  function automatic logic [3:0] net_b(input logic [15:0] x);
    return x[7:4] ^ x[3:0] ^ 4'h8;
  endfunction

  assign z     = net_b(xb);
  assign z_s1  = net_b(xb_s1);
  assign z_s15 = net_b(xb_s15);

  always #5 clock = ~clock;

  arbitro_rete_b #(.SETTLE_CYCLES(2)) u_dut (
    .clock(clock), .reset_(reset_),
    .req0(req0), .op0(op0), .ack0(ack0),
    .req1(req1), .op1(op1), .ack1(ack1),
    .dato(dato), .x15_x0_b(xb), .z3_z0_b(z),
    .grant(grant), .busy(busy)
  );

  arbitro_rete_b #(.SETTLE_CYCLES(1)) u_dut_s1 (
    .clock(clock), .reset_(reset_),
    .req0(req0), .op0(op0), .ack0(ack0_s1),
    .req1(req1), .op1(op1), .ack1(ack1_s1),
    .dato(dato_s1), .x15_x0_b(xb_s1), .z3_z0_b(z_s1),
    .grant(grant_s1), .busy(busy_s1)
  );

  arbitro_rete_b #(.SETTLE_CYCLES(15)) u_dut_s15 (
    .clock(clock), .reset_(reset_),
    .req0(req0), .op0(op0), .ack0(ack0_s15),
    .req1(req1), .op1(op1), .ack1(ack1_s15),
    .dato(dato_s15), .x15_x0_b(xb_s15), .z3_z0_b(z_s15),
    .grant(grant_s15), .busy(busy_s15)
  );

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    vectors++;
    if (got !== exp) begin
      miscompares++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  task automatic step();
    @(posedge clock);
    #1;
  endtask

  task automatic do_reset();
    reset_ = 1'b0;
    req0 = 1'b0; req1 = 1'b0; op0 = '0; op1 = '0;
    step();
    reset_ = 1'b1;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog");
  end

  initial begin
    int t_g[3];
    int t_a[3];

    // Reset held with a request pending.
    reset_ = 1'b0; req0 = 1'b1; op0 = 16'hA5A5;
    step(); step();
    check("rst_ack0", ack0, 0);
    check("rst_ack1", ack1, 0);
    check("rst_dato", dato, 0);
    check("rst_busy", busy, 0);
    check("rst_x", xb, 0);
    reset_ = 1'b1;
    step();
    check("first_busy", busy, 1);
    check("first_grant", grant, 0);
    check("first_x", xb, 16'hA5A5);
    check("first_ack_early", ack0, 0);
    step();
    check("first_ack_e1", ack0, 0);
    step();
    check("first_ack0", ack0, 1);
    check("first_dato", dato, 4'h7);
    req0 = 1'b0;
    step();
    check("first_ack_fall", ack0, 0);
    check("first_idle", busy, 0);
    check("first_x_kept", xb, 16'hA5A5);

    // Contention from reset.
    do_reset();
    req0 = 1'b1; req1 = 1'b1; op0 = 16'h0001; op1 = 16'h1234;
    step();
    check("cont_grant0", grant, 0);
    check("cont_x0", xb, 16'h0001);
    step(); step();
    check("cont_ack0", ack0, 1);
    check("cont_ack1_low", ack1, 0);
    check("cont_dato0", dato, 4'h9);
    req0 = 1'b0;
    step();
    check("cont_ack0_fall", ack0, 0);
    check("cont_idle", busy, 0);
    req0 = 1'b1;
    step();
`ifdef ARBITRO_PRIO_FISSA_EN
    check("prio_regrant0", grant, 0);
    step(); step();
    check("prio_ack0", ack0, 1);
    check("prio_ack1_low", ack1, 0);
`else
    check("rr_grant1", grant, 1);
    check("rr_x1", xb, 16'h1234);
    step(); step();
    check("rr_ack1", ack1, 1);
    check("rr_ack0_low", ack0, 0);
    check("rr_dato1", dato, 4'hF);
    req1 = 1'b0;
    step();
    check("rr_ack1_fall", ack1, 0);
    req1 = 1'b1;
    step();
    check("rr_grant_back0", grant, 0);
    check("rr_x_back0", xb, 16'h0001);
`endif

    // Operand changes during SETTLE are ignored.
    do_reset();
    req0 = 1'b1; op0 = 16'h0001;
    step();
    op0 = 16'hFFFF;
    step();
    check("stab_x_mid", xb, 16'h0001);
    step();
    check("stab_ack0", ack0, 1);
    check("stab_x", xb, 16'h0001);
    check("stab_dato", dato, 4'h9);
    req0 = 1'b0;
    step();

    // Granted client drops req mid-SETTLE while client 0 waits.
    do_reset();
    req1 = 1'b1; op1 = 16'h1234;
    step();
    check("drop_grant1", grant, 1);
    req1 = 1'b0; req0 = 1'b1; op0 = 16'hA5A5;
    step();
    check("drop_ack1_pre", ack1, 0);
    step();
    check("drop_ack1_pulse", ack1, 1);
    check("drop_dato", dato, 4'hF);
    check("drop_ack0_wait", ack0, 0);
    step();
    check("drop_ack1_clr", ack1, 0);
    check("drop_idle", busy, 0);
    step();
    check("drop_grant0", grant, 0);
    check("drop_x0", xb, 16'hA5A5);
    step(); step();
    check("drop_ack0", ack0, 1);
    check("drop_dato0", dato, 4'h7);

    // Reset asserted in SETTLE.
    do_reset();
    req0 = 1'b1; op0 = 16'h0001;
    step();
    step();
    reset_ = 1'b0;
    #1;
    check("mrst_busy", busy, 0);
    check("mrst_ack0", ack0, 0);
    check("mrst_x", xb, 0);
    step();
    reset_ = 1'b1;
    step();
    check("mrst_regrant", busy, 1);
    check("mrst_x_new", xb, 16'h0001);
    step();
    check("mrst_ack_e1", ack0, 0);
    step();
    check("mrst_ack0", ack0, 1);

    // Grant-to-ack latency at SETTLE_CYCLES = 2, 1 and 15.
    do_reset();
    op0 = 16'h00F0; req0 = 1'b1;
    for (int k = 0; k < 3; k++) begin
      t_g[k] = -1;
      t_a[k] = -1;
    end
    for (int c = 1; c <= 40; c++) begin
      step();
      if (t_g[0] < 0 && busy)     t_g[0] = c;
      if (t_a[0] < 0 && ack0)     t_a[0] = c;
      if (t_g[1] < 0 && busy_s1)  t_g[1] = c;
      if (t_a[1] < 0 && ack0_s1)  t_a[1] = c;
      if (t_g[2] < 0 && busy_s15) t_g[2] = c;
      if (t_a[2] < 0 && ack0_s15) t_a[2] = c;
    end
    check("lat_grant_s2", t_g[0], 1);
    check("lat_s2", t_a[0] - t_g[0], 2);
    check("lat_s1", t_a[1] - t_g[1], 1);
    check("lat_s15", t_a[2] - t_g[2], 15);
    check("s15_ack_held", ack0_s15, 1);
    check("s15_dato", dato_s15, 4'h7);
    check("s15_x", xb_s15, 16'h00F0);
    check("s1_dato", dato_s1, 4'h7);
    req0 = 1'b0;
    step();
    check("s15_release", busy_s15, 0);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule

`default_nettype wire
